gray_decoder_serial: RTL and testbench

Bit-serial Gray-to-binary decoder. It is the receive-side counterpart of the binary-to-Gray encoder.
- Accepts a WIDTH-bit Gray word over a valid/ready handshake.
- Resolves one binary bit per clock, MSB first, then presents the binary word on a second valid/ready handshake.
- Tracks the previously delivered word and flags whether consecutive words are adjacent (+/-1 modulo 2^WIDTH), which is the expected pattern for a Gray-coded counter stream.

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray_step_check.sv | 24 ++
 rtl/gray_decoder_serial.sv | 145 ++++++++++++++
 tb/tb_gray_decoder_serial.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and defaults for the bit-serial Gray-to-binary decoder.
package gray_pkg;

    // Decoder FSM: wait for a word, resolve it bit by bit, present the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } gray_dec_state_t;

    localparam int GRAY_DEFAULT_WIDTH = 8;

endpackage : gray_pkg

// File: rtl/gray_step_check.sv
// Adjacency check between a freshly decoded word and the previously delivered
// one. Purely combinational; the caller registers the result.
module gray_step_check
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    input  logic             have_prev,
    output logic             first,
    output logic             step_ok
);

    logic [WIDTH-1:0] diff;

    // Natural WIDTH-bit wrap makes max->0 and 0->max both look like +/-1.
    always_comb begin
        diff    = cur - prev;
        first   = !have_prev;
        step_ok = have_prev && ((diff == WIDTH'(1)) || (diff == {WIDTH{1'b1}}));
    end

endmodule : gray_step_check

// File: rtl/gray_decoder_serial.sv
// Bit-serial Gray-to-binary decoder. One binary bit is resolved per clock,
// MSB first; the finished word is held on an output handshake together with
// flags saying whether it is adjacent to the previously delivered word.
module gray_decoder_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_first,
    output logic             out_step_ok
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    gray_dec_state_t  state_q,     state_d;
    logic [WIDTH-1:0] gray_q,      gray_d;      // Gray word, current bit at MSB
    logic [WIDTH-1:0] acc_q,       acc_d;       // binary bits resolved so far
    logic [IDX_W-1:0] idx_q,       idx_d;       // bit index being resolved
    logic             carry_q,     carry_d;     // previously resolved binary bit
    logic [WIDTH-1:0] bin_q,       bin_d;       // word presented in HOLD
    logic             first_q,     first_d;
    logic             step_ok_q,   step_ok_d;
    logic [WIDTH-1:0] prev_q,      prev_d;      // last word actually delivered
    logic             have_prev_q, have_prev_d;

    logic             cur_bit;
    logic             last_bit;
    logic [WIDTH-1:0] word_done;
    logic             chk_first;
    logic             chk_step_ok;

    // Handshake flags come straight from registered state.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign out_bin     = bin_q;
    assign out_first   = first_q;
    assign out_step_ok = step_ok_q;

    // Binary bit for the current index and the full word as it will look
    // once bit 0 lands; only meaningful on the final SHIFT edge.
    always_comb begin
        cur_bit      = carry_q ^ gray_q[WIDTH-1];
        last_bit     = (idx_q == '0);
        word_done    = acc_q;
        word_done[0] = cur_bit;
    end

    gray_step_check #(
        .WIDTH(WIDTH)
    ) u_step_check (
        .cur      (word_done),
        .prev     (prev_q),
        .have_prev(have_prev_q),
        .first    (chk_first),
        .step_ok  (chk_step_ok)
    );

    // Next-state logic; clr overrides every handshake in the same cycle.
    always_comb begin
        state_d     = state_q;
        gray_d      = gray_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        bin_d       = bin_q;
        first_d     = first_q;
        step_ok_d   = step_ok_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;

        if (clr) begin
            state_d     = IDLE;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        gray_d  = in_gray;
                        acc_d   = '0;
                        idx_d   = IDX_W'(WIDTH - 1);
                        carry_d = 1'b0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    acc_d[idx_q] = cur_bit;
                    carry_d      = cur_bit;
                    gray_d       = {gray_q[WIDTH-2:0], 1'b0};
                    idx_d        = idx_q - IDX_W'(1);
                    if (last_bit) begin
                        bin_d     = word_done;
                        first_d   = chk_first;
                        step_ok_d = chk_step_ok;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        prev_d      = bin_q;
                        have_prev_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gray_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            bin_q       <= '0;
            first_q     <= 1'b1;
            step_ok_q   <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gray_q      <= gray_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            bin_q       <= bin_d;
            first_q     <= first_d;
            step_ok_q   <= step_ok_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end

endmodule : gray_decoder_serial

// File: tb/tb_gray_decoder_serial.sv
// Directed bench for gray_decoder_serial (WIDTH=8) with a word-level
// reference model checked every cycle plus hand-computed expectations.
module tb_gray_decoder_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_gray = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_first;
    logic         out_step_ok;
    logic [W-1:0] out_bin;

    int total = 0;
    int bad   = 0;

    gray_decoder_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_gray    (in_gray),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_first  (out_first),
        .out_step_ok(out_step_ok)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Gray to binary as a prefix XOR of all right shifts.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic adj(input logic [W-1:0] cur, input logic [W-1:0] prv, input logic hv);
        logic [W-1:0] d;
        d = cur - prv;
        return hv && ((d == 8'd1) || (d == 8'hFF));
    endfunction

    // Reference model: phase 0 = waiting, 1 = busy, 2 = presenting.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_word  = '0;
    logic [W-1:0] m_bin   = '0;
    logic [W-1:0] m_prev  = '0;
    logic         m_have  = 1'b0;
    logic         m_first = 1'b1;
    logic         m_ok    = 1'b0;

    // Model update on the same edges the DUT sees.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_bin   <= '0;
            m_prev  <= '0;
            m_have  <= 1'b0;
            m_first <= 1'b1;
            m_ok    <= 1'b0;
        end else if (clr) begin
            m_phase <= 0;
            m_have  <= 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_word  <= in_gray;
                m_left  <= W;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_bin   <= g2b(m_word);
                m_first <= !m_have;
                m_ok    <= adj(g2b(m_word), m_prev, m_have);
                m_phase <= 2;
            end
        end else begin
            if (out_ready) begin
                m_prev  <= m_bin;
                m_have  <= 1'b1;
                m_phase <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == 0);
        chk("out_valid", out_valid, m_phase == 2);
        if (m_phase == 2 || rst) begin
            chk("out_bin", out_bin, m_bin);
            chk("out_first", out_first, m_first);
            chk("out_step_ok", out_step_ok, m_ok);
        end
    end

    // Offer a word and return right after the edge that accepts it.
    task automatic send(input logic [W-1:0] g);
        int n;
        in_gray  = g;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 64, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic deliver();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        chk("idle_after_xfer", in_ready, 1);
    endtask

    task automatic xfer(input logic [W-1:0] g, input logic [W-1:0] eb, input logic ef, input logic eo);
        int lat;
        send(g);
        wait_out(lat);
        chk("latency", lat, W);
        chk("lit_bin", out_bin, eb);
        chk("lit_first", out_first, ef);
        chk("lit_step_ok", out_step_ok, eo);
        deliver();
    endtask

    initial begin
        int lat;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_bin", out_bin, 8'h00);
        chk("rst_out_first", out_first, 1);
        chk("rst_step_ok", out_step_ok, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic decode, adjacency, wrap in both directions, non-adjacent, equal.
        xfer(8'hE6, 8'hBB, 1'b1, 1'b0);
        xfer(8'hE2, 8'hBC, 1'b0, 1'b1);
        xfer(8'h80, 8'hFF, 1'b0, 1'b0);
        xfer(8'h00, 8'h00, 1'b0, 1'b1);
        xfer(8'h80, 8'hFF, 1'b0, 1'b1);
        xfer(8'h00, 8'h00, 1'b0, 1'b1);
        xfer(8'h07, 8'h05, 1'b0, 1'b0);
        xfer(8'h07, 8'h05, 1'b0, 1'b0);

        // Backpressure: outputs frozen while the input side is noisy.
        send(8'h01);
        wait_out(lat);
        chk("bp_latency", lat, W);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_gray   = 8'($urandom);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_bin", out_bin, 8'h01);
            chk("bp_out_first", out_first, 0);
            chk("bp_step_ok", out_step_ok, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        xfer(8'h03, 8'h02, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a decode.
        send(8'h0F);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_bin", out_bin, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(8'h07, 8'h05, 1'b1, 1'b0);

        // clr together with out_ready in HOLD: no transfer, history erased.
        send(8'hE6);
        wait_out(lat);
        chk("clr_latency", lat, W);
        chk("clr_pre_bin", out_bin, 8'hBB);
        chk("clr_pre_first", out_first, 0);
        @(negedge clk);
        clr       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_keeps_bin", out_bin, 8'hBB);
        @(negedge clk);
        clr       = 1'b0;
        out_ready = 1'b0;
        xfer(8'hE2, 8'hBC, 1'b1, 1'b0);
        xfer(8'hE6, 8'hBB, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule : tb_gray_decoder_serial
